// File: rtl/hazard_unit_mc.sv
// Stateful hazard unit for the 5-stage RISC-V pipeline: operand forwarding, load-use
// and mul/div stalls, data-memory wait stalls, branch flushes and saturating counters.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 3,
    parameter int LU_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE0,
    input  logic                  PcSrcE,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  MdStartE,
    input  logic                  MdDone,
    input  logic                  MemReqM,
    input  logic                  MemAckM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount,
    output logic [1:0]            state_dbg_o,
    output logic [1:0]            lu_cnt_dbg_o
);

    // Handshakes: MdStartE stays high while the mul/div op sits in E and MdDone marks
    // the single cycle its result is valid; MemReqM stays high until the MemAckM cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LU   = 2'd1,
        S_MD   = 2'd2
    } state_e;

    localparam logic [1:0]       LU_LOAD = 2'(LU_PENALTY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       load_use, mem_wait, br_flush;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a, fwd_b;

    // M-stage result is younger than W, so it takes priority; x0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0)) begin
            fwd_a = 2'b10;
        end else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) begin
            fwd_a = 2'b01;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0)) begin
            fwd_b = 2'b10;
        end else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) begin
            fwd_b = 2'b01;
        end
    end

    assign load_use = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign mem_wait = MemReqM && !MemAckM;

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        flush_w  = 1'b0;
        br_flush = 1'b0;
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        if (mem_wait) begin
            // Freeze F..M and bubble W; the FSM and its countdown are paused.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MdStartE && !MdDone) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        state_d = S_MD;
                    end else if (PcSrcE) begin
                        flush_d  = 1'b1;
                        flush_e  = 1'b1;
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LU_PENALTY > 1) begin
                            lu_cnt_d = LU_LOAD;
                            state_d  = S_LU;
                        end
                    end
                end
                S_LU: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                    lu_cnt_d = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) begin
                        state_d = S_IDLE;
                    end
                end
                S_MD: begin
                    if (!MdDone) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    lu_cnt_d = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (br_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lu_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every output low immediately, forward selects included.
    assign StallF       = rst & stall_f;
    assign StallD       = rst & stall_d;
    assign StallE       = rst & stall_e;
    assign StallM       = rst & stall_m;
    assign FlushD       = rst & flush_d;
    assign FlushE       = rst & flush_e;
    assign FlushM       = rst & flush_m;
    assign FlushW       = rst & flush_w;
    assign ForwardAE    = rst ? fwd_a : 2'b00;
    assign ForwardBE    = rst ? fwd_b : 2'b00;
    assign StallCount   = stall_cnt_q;
    assign FlushCount   = flush_cnt_q;
    assign state_dbg_o  = state_q;
    assign lu_cnt_dbg_o = lu_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: instance a (LU_PENALTY=2, CNT_W=16) and instance b
// (LU_PENALTY=1, CNT_W=2) share stimulus and are checked against a cycle model.
module tb_hazard_unit_mc;

    localparam int RW = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LU   = 2'd1;
    localparam logic [1:0] ST_MD   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic RegWriteM, RegWriteW, ResultSrcE0, PcSrcE;
    logic MdStartE, MdDone, MemReqM, MemAckM;
    logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

    logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a, fw_a;
    logic [1:0] fa_a, fb_a, st_a, lc_a;
    logic [15:0] sc_a, fc_a;
    logic sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fm_b, fw_b;
    logic [1:0] fa_b, fb_b, st_b, lc_b;
    logic [1:0] sc_b, fc_b;

    hazard_unit_mc #(.REG_ADDR_W(RW), .LU_PENALTY(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PcSrcE(PcSrcE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MdStartE(MdStartE), .MdDone(MdDone), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .StallM(sm_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a), .FlushW(fw_a),
        .ForwardAE(fa_a), .ForwardBE(fb_a), .StallCount(sc_a), .FlushCount(fc_a),
        .state_dbg_o(st_a), .lu_cnt_dbg_o(lc_a)
    );

    hazard_unit_mc #(.REG_ADDR_W(RW), .LU_PENALTY(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PcSrcE(PcSrcE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MdStartE(MdStartE), .MdDone(MdDone), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .StallM(sm_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b), .FlushW(fw_b),
        .ForwardAE(fa_b), .ForwardBE(fb_b), .StallCount(sc_b), .FlushCount(fc_b),
        .state_dbg_o(st_b), .lu_cnt_dbg_o(lc_b)
    );

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    int pen[2];
    int cmax[2];
    logic [1:0] m_st[2], m_st_n[2], m_cnt[2], m_cnt_n[2];
    int m_sc[2], m_sc_n[2], m_fc[2], m_fc_n[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs);
        if (RegWriteM && RdM == rs && rs != 0) return 2'b10;
        if (RegWriteW && RdW == rs && rs != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = ST_IDLE;
            m_cnt[i] = 2'd0;
            m_sc[i] = 0;
            m_fc[i] = 0;
        end
    endtask

    // Expected word: [7:0] {SF,SD,SE,SM,FD,FE,FM,FW}, [9:8] FwdA, [11:10] FwdB,
    // [13:12] state, [15:14] lu_cnt, [31:16] StallCount, [47:32] FlushCount.
    task automatic model_eval(input int i, output logic [63:0] e);
        logic [7:0] c;
        logic [1:0] fa, fb;
        logic mw, lu, brf;
        c = 8'h00; fa = 2'b00; fb = 2'b00; brf = 1'b0;
        m_st_n[i] = m_st[i]; m_cnt_n[i] = m_cnt[i];
        m_sc_n[i] = m_sc[i]; m_fc_n[i] = m_fc[i];
        if (rst) begin
            fa = fwd_sel(Rs1E);
            fb = fwd_sel(Rs2E);
            mw = MemReqM && !MemAckM;
            lu = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
            if (mw) begin
                c = 8'b1111_0001;
            end else if (m_st[i] == ST_IDLE) begin
                if (MdStartE && !MdDone) begin
                    c = 8'b1110_0010; m_st_n[i] = ST_MD;
                end else if (PcSrcE) begin
                    c = 8'b0000_1100; brf = 1'b1;
                end else if (lu) begin
                    c = 8'b1100_0100;
                    if (pen[i] > 1) begin
                        m_st_n[i] = ST_LU; m_cnt_n[i] = 2'(pen[i] - 1);
                    end
                end
            end else if (m_st[i] == ST_LU) begin
                c = 8'b1100_0100;
                m_cnt_n[i] = m_cnt[i] - 2'd1;
                if (m_cnt[i] == 2'd1) m_st_n[i] = ST_IDLE;
            end else begin
                if (!MdDone) c = 8'b1110_0010;
                else m_st_n[i] = ST_IDLE;
            end
            if (c[7] && m_sc[i] < cmax[i]) m_sc_n[i] = m_sc[i] + 1;
            if (brf && m_fc[i] < cmax[i]) m_fc_n[i] = m_fc[i] + 1;
        end
        e = {16'h0, 16'(m_fc[i]), 16'(m_sc[i]), m_cnt[i], m_st[i], fb, fa, c};
    endtask

    task automatic cmp_word(input string who, input logic [63:0] got, input logic [63:0] exp);
        check_eq({who, ".ctrl"}, 32'(got[7:0]),   32'(exp[7:0]));
        check_eq({who, ".fwd"},  32'(got[11:8]),  32'(exp[11:8]));
        check_eq({who, ".state"}, 32'(got[13:12]), 32'(exp[13:12]));
        check_eq({who, ".lucnt"}, 32'(got[15:14]), 32'(exp[15:14]));
        check_eq({who, ".scnt"}, 32'(got[31:16]), 32'(exp[31:16]));
        check_eq({who, ".fcnt"}, 32'(got[47:32]), 32'(exp[47:32]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_in();
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PcSrcE = 0;
        MdStartE = 0; MdDone = 0; MemReqM = 0; MemAckM = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    endtask

    task automatic run_cycle();
        logic [63:0] e, got;
        if (!rst) reset_model();
        model_eval(0, e); exp_a_q.push_back(e);
        model_eval(1, e); exp_b_q.push_back(e);
        @(negedge clk);
        e = exp_a_q.pop_front();
        got = {16'h0, fc_a, sc_a, lc_a, st_a, fb_a, fa_a,
               sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a, fw_a};
        cmp_word("a", got, e);
        e = exp_b_q.pop_front();
        got = {16'h0, 14'h0, fc_b, 14'h0, sc_b, lc_b, st_b, fb_b, fa_b,
               sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fm_b, fw_b};
        cmp_word("b", got, e);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_st[i] = m_st_n[i]; m_cnt[i] = m_cnt_n[i];
            m_sc[i] = m_sc_n[i]; m_fc[i] = m_fc_n[i];
        end
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        clr_in();
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    task automatic set_load_use(input logic [RW-1:0] rd, input logic [RW-1:0] rs2);
        ResultSrcE0 = 1; RdE = rd; Rs2D = rs2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pen[0] = 2; pen[1] = 1;
        cmax[0] = 65535; cmax[1] = 3;
        reset_model();
        clr_in();
        rst = 0;
        run_cycle();
        run_cycle();
        rst = 1;
        idle_cycles(2);

        // forwarding priority and x0 exclusion
        RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 3; Rs1E = 5; Rs2E = 3;
        run_cycle();
        RdW = 5; Rs2E = 5;
        run_cycle();
        Rs1E = 0; RdM = 0; Rs2E = 2;
        run_cycle();
        RegWriteM = 0; RdM = 6; RdW = 6; Rs1E = 6; Rs2E = 6;
        run_cycle();
        idle_cycles(1);

        // load-use via Rs2D, then via Rs1D, then load to x0
        set_load_use(4, 4);
        run_cycle();
        idle_cycles(2);
        ResultSrcE0 = 1; RdE = 2; Rs1D = 2;
        run_cycle();
        idle_cycles(2);
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        run_cycle();
        idle_cycles(1);

        // taken branch beats simultaneous load-use
        set_load_use(4, 4); PcSrcE = 1;
        run_cycle();
        idle_cycles(1);

        // multi-cycle mul/div: 3 stall cycles, then done
        MdStartE = 1;
        run_cycle(); run_cycle(); run_cycle();
        MdDone = 1;
        run_cycle();
        idle_cycles(1);
        MdStartE = 1; MdDone = 1;
        run_cycle();
        MdDone = 0; PcSrcE = 1;
        run_cycle();
        PcSrcE = 0; MdDone = 1;
        run_cycle();
        idle_cycles(1);

        // memory wait in the middle of a load-use stall
        set_load_use(4, 4);
        run_cycle();
        clr_in(); MemReqM = 1;
        run_cycle(); run_cycle();
        MemAckM = 1;
        run_cycle();
        idle_cycles(2);
        MemReqM = 1; set_load_use(3, 3);
        run_cycle();
        MemAckM = 1;
        run_cycle();
        idle_cycles(2);

        // reset in the middle of a mul/div stall
        MdStartE = 1;
        run_cycle(); run_cycle();
        rst = 0;
        run_cycle();
        rst = 1;
        clr_in();
        run_cycle();

        // five load-use cycles saturate the 2-bit counter of instance b at 3
        set_load_use(5, 5);
        for (int k = 0; k < 5; k++) run_cycle();
        idle_cycles(2);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = ($urandom_range(0, 2) == 0);
            PcSrcE      = ($urandom_range(0, 5) == 0);
            MdStartE    = ($urandom_range(0, 4) == 0);
            MdDone      = ($urandom_range(0, 2) == 0);
            MemReqM     = ($urandom_range(0, 3) == 0);
            MemAckM     = 1'($urandom_range(0, 1));
            Rs1D = RW'($urandom_range(0, 3)); Rs2D = RW'($urandom_range(0, 3));
            Rs1E = RW'($urandom_range(0, 3)); Rs2E = RW'($urandom_range(0, 3));
            RdE  = RW'($urandom_range(0, 3)); RdM  = RW'($urandom_range(0, 3));
            RdW  = RW'($urandom_range(0, 3));
            run_cycle();
        end
        idle_cycles(3);

        check_eq("queue_a_empty", 32'(exp_a_q.size()), 32'd0);
        check_eq("queue_b_empty", 32'(exp_b_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised, stateful hazard unit for the 5-stage RISC-V pipeline.
- Keeps the existing forwarding, load-use stall and branch-flush duties.
- Adds a configurable multi-cycle load-use penalty, a stall-until-done handshake with the multi-cycle mul/div unit in E, data-memory wait stalls in M, and saturating stall/flush performance counters.
- Sits beside the datapath and drives the enable/clear inputs of the F/D/E/M/W pipeline registers.

Parameters:
REG_ADDR_W, 3, register address width (3 gives 8 architectural registers).
LU_PENALTY, 1, bubble cycles inserted per load-use hazard; legal range 1..3.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  pipeline clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
RegWriteM, RegWriteW  in  1  register write enables in M and W.
ResultSrcE0  in  1  E-stage instruction is a load.
PcSrcE  in  1  E-stage branch/jump taken.
Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_ADDR_W  stage register addresses.
MdStartE  in  1  multi-cycle mul/div op present in E.
MdDone  in  1  mul/div result valid this cycle.
MemReqM  in  1  load/store access in M.
MemAckM  in  1  data memory completes access this cycle.
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
FlushD, FlushE, FlushM, FlushW  out  1  clear the corresponding pipeline register (bubble).
ForwardAE, ForwardBE  out  2  operand mux select: 00 register file, 01 W result, 10 M result.
StallCount, FlushCount  out  CNT_W  performance counters.

Behaviour:
Reset
- While rst=0: state=IDLE, lu_cnt=0, both counters 0, and every output 0 (forward selects included).
- Reset is allowed mid-stall; the FSM restarts in IDLE on release.

Forwarding (combinational)
- ForwardAE=10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
- Else ForwardAE=01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
- Else ForwardAE=00.
- ForwardBE follows the same rules using Rs2E.

Hazard detection
- lu = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). A load to x0 never stalls.
- mw = MemReqM & ~MemAckM.

Memory wait (overrides every state)
- While mw: StallF=StallD=StallE=StallM=1 and FlushW=1.
- All other flushes are 0.
- FSM state and lu_cnt hold.
- In the MemAckM cycle, normal outputs resume.

FSM states: IDLE, LU, MD. Evaluated only when mw=0.
IDLE, first match wins:
- a) MdStartE & ~MdDone: StallF=StallD=StallE=1, FlushM=1; next state MD.
- b) PcSrcE: FlushD=FlushE=1, no stalls. A taken branch suppresses a simultaneous load-use stall.
- c) lu: StallF=StallD=1, FlushE=1. If LU_PENALTY>1, load lu_cnt=LU_PENALTY-1 and go to LU; otherwise stay in IDLE.
- d) Otherwise all stall/flush outputs 0.
- MdStartE & MdDone in the same cycle is a single-cycle op: no stall.
LU:
- StallF=StallD=1, FlushE=1.
- lu_cnt decrements each cycle; when lu_cnt==1, next state is IDLE.
- lu is not re-evaluated in LU.
MD:
- While ~MdDone: StallF=StallD=StallE=1, FlushM=1.
- In the MdDone cycle all outputs are 0 and next state is IDLE.
- rst is the only abort.

Counters
- StallCount +1 every cycle StallF=1.
- FlushCount +1 every cycle FlushD=1 caused by PcSrcE.
- Both saturate at 2^CNT_W-1 (no wrap).

Test Plan:
1. rst=0 then 1 after 2 cycles, all inputs 0 -> all outputs 0, counters 0, state IDLE.
2. RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1; Rs2E=3, RdW=3 case -> ForwardAE=10, ForwardBE=01; Rs1E=0 with RdM=0 -> ForwardAE=00.
3. LU_PENALTY=2: ResultSrcE0=1, RdE=4, Rs2D=4 -> StallF=StallD=FlushE=1 for exactly 2 cycles, StallCount=2; repeat with RdE=0 -> no stall.
4. PcSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0, FlushCount=1.
5. MdStartE=1, MdDone rises 3 cycles later -> StallF/D/E=1 and FlushM=1 for 3 cycles, all 0 in the MdDone cycle, state IDLE next.
6. In LU state, MemReqM=1, MemAckM=0 for 2 cycles -> StallF/D/E/M=1 and FlushW=1, lu_cnt held; LU then completes its remaining cycles after MemAckM. Separately, with CNT_W=2, force 5 stall cycles -> StallCount=3.
